// File: rtl/csa_pkg.sv
// Shared constants for the serial word adder: slice width and FSM encodings.
package csa_pkg;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/cla_adder_4.sv
// 4-bit carry-lookahead adder: {cout, sum} = a + b + c, purely combinational.
module cla_adder_4 (
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       c_in,
    output logic [4:0] sum_out
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a_in & b_in;
    assign p_s = a_in ^ b_in;

    // Every carry is a flat sum of products of generate/propagate terms and c_in.
    assign c_s[0] = c_in;
    assign c_s[1] = g_s[0] | (p_s[0] & c_in);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_in);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_in);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_in);

    assign sum_out = {c_s[4], p_s ^ c_s[3:0]};
endmodule

// File: rtl/cla_serial_word_adder.sv
// Multi-cycle wide adder: feeds one cla_adder_4 a 4-bit slice per clock, LSB first,
// holding the carry between cycles, and posts {cout,sum} with a one-cycle done pulse.
module cla_serial_word_adder
    import csa_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              start_in,
    input  logic [SLICE_W*NUM_SLICES-1:0]     a_in,
    input  logic [SLICE_W*NUM_SLICES-1:0]     b_in,
    input  logic                              c_in,
    output logic                              busy_out,
    output logic                              done_out,
    output logic [SLICE_W*NUM_SLICES:0]       sum_out
);
    localparam int WORD_W = SLICE_W * NUM_SLICES;
    localparam int CNT_W  = $clog2(NUM_SLICES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    state_t              state_r;
    logic [WORD_W-1:0]   a_sh_r;
    logic [WORD_W-1:0]   b_sh_r;
    logic [WORD_W-1:0]   res_r;
    logic                carry_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [4:0]          slice_sum_s;
    logic [WORD_W+3:0]   res_wide_s;
    logic [WORD_W-1:0]   res_next_s;

    cla_adder_4 u_cla (
        .a_in    (a_sh_r[SLICE_W-1:0]),
        .b_in    (b_sh_r[SLICE_W-1:0]),
        .c_in    (carry_r),
        .sum_out (slice_sum_s)
    );

    // Widening before the shift keeps the expression legal when WORD_W equals one slice.
    assign res_wide_s = {slice_sum_s[3:0], res_r};
    assign res_next_s = res_wide_s[WORD_W+3:4];

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r  <= ST_IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_r    <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            sum_out  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        a_sh_r   <= a_in;
                        b_sh_r   <= b_in;
                        carry_r  <= c_in;
                        cnt_r    <= '0;
                        busy_out <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    done_out <= 1'b0;
                    res_r    <= res_next_s;
                    carry_r  <= slice_sum_s[4];
                    a_sh_r   <= a_sh_r >> SLICE_W;
                    b_sh_r   <= b_sh_r >> SLICE_W;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // carry_r/res_r hold the completed result here, so the post is never partial.
                    sum_out  <= {carry_r, res_r};
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
